// File: rtl/sum_rr_sched_pkg.sv
// Shared definitions for the round-robin shared-adder scheduler.
// Saturating sum is selected at build time with SUM_RR_SCHED_SAT_EN.
package sum_rr_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic int calc_nb_id(input int n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

endpackage

// File: rtl/sum_rr_pick.sv
// Combinational round-robin picker: first valid requester at or above ptr, with wrap.
module sum_rr_pick #(
    parameter int N_REQ = 4,
    parameter int NB_ID = 2
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [NB_ID-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [NB_ID-1:0] grant_idx,
    output logic             any_valid
);

    always_comb begin
        int k;
        grant     = '0;
        grant_idx = '0;
        any_valid = 1'b0;
        k         = 0;
        for (int i = 0; i < N_REQ; i++) begin
            k = (int'(ptr) + i) % N_REQ;
            if (!any_valid && valid[k]) begin
                any_valid = 1'b1;
                grant[k]  = 1'b1;
                grant_idx = NB_ID'(k);
            end
        end
    end

endmodule

// File: rtl/sum_rr_sched.sv
// Round-robin scheduler sharing one unsigned adder among N_REQ requesters.
// Build option SUM_RR_SCHED_SAT_EN saturates the sum on carry out.
//
// state   | meaning
// IDLE    | grant offered to the next valid requester, accept captures operands
// CALC    | one-cycle add, result registers loaded
// RESP    | result presented until the consumer takes it
module sum_rr_sched
    import sum_rr_sched_pkg::*;
#(
    parameter int  N_REQ   = 4,
    parameter int  NB_DATA = 3,
    localparam int NB_ID   = calc_nb_id(N_REQ)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [N_REQ-1:0]         i_req_valid,
    output logic [N_REQ-1:0]         o_req_ready,
    input  logic [N_REQ*NB_DATA-1:0] i_data1,
    input  logic [N_REQ*NB_DATA-1:0] i_data2,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [NB_DATA-1:0]       o_rsp_sum,
    output logic                     o_rsp_ovf,
    output logic [NB_ID-1:0]         o_rsp_id,
    output logic                     o_busy
);

    state_t             state_q, state_d;
    logic [NB_ID-1:0]   ptr_q;
    logic [NB_DATA-1:0] op1_q, op2_q;
    logic [NB_ID-1:0]   id_q;
    logic [N_REQ-1:0]   pick_grant;
    logic [NB_ID-1:0]   pick_idx;
    logic               pick_any;
    logic               accept;
    logic [NB_DATA:0]   sum_full;
    logic [NB_DATA-1:0] sum_res;

    sum_rr_pick #(
        .N_REQ (N_REQ),
        .NB_ID (NB_ID)
    ) u_pick (
        .valid     (i_req_valid),
        .ptr       (ptr_q),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .any_valid (pick_any)
    );

    // Ready is forced low while reset is asserted, even with requesters valid.
    assign o_req_ready = (state_q == ST_IDLE && i_rst_n) ? pick_grant : '0;
    assign accept      = (state_q == ST_IDLE) && pick_any;
    assign o_rsp_valid = (state_q == ST_RESP);
    assign o_busy      = (state_q != ST_IDLE);

    assign sum_full = {1'b0, op1_q} + {1'b0, op2_q};
`ifdef SUM_RR_SCHED_SAT_EN
    assign sum_res = sum_full[NB_DATA] ? {NB_DATA{1'b1}} : sum_full[NB_DATA-1:0];
`else
    assign sum_res = sum_full[NB_DATA-1:0];
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (pick_any)    state_d = ST_CALC;
            ST_CALC:                  state_d = ST_RESP;
            ST_RESP: if (i_rsp_ready) state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_q     <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            id_q      <= '0;
            o_rsp_sum <= '0;
            o_rsp_ovf <= 1'b0;
            o_rsp_id  <= '0;
        end else begin
            if (accept) begin
                op1_q <= i_data1[pick_idx*NB_DATA +: NB_DATA];
                op2_q <= i_data2[pick_idx*NB_DATA +: NB_DATA];
                id_q  <= pick_idx;
                if (pick_idx == NB_ID'(N_REQ-1)) begin
                    ptr_q <= '0;
                end else begin
                    ptr_q <= pick_idx + 1'b1;
                end
            end
            if (state_q == ST_CALC) begin
                o_rsp_sum <= sum_res;
                o_rsp_ovf <= sum_full[NB_DATA];
                o_rsp_id  <= id_q;
            end
        end
    end

endmodule

// File: tb/tb_sum_rr_sched.sv
// Directed self-checking bench for sum_rr_sched (N_REQ=4, NB_DATA=3).
module tb_sum_rr_sched;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [11:0] data1;
    logic [11:0] data2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [2:0]  rsp_sum;
    logic        rsp_ovf;
    logic [1:0]  rsp_id;
    logic        busy;

    int checks = 0;
    int passes = 0;

    sum_rr_sched #(
        .N_REQ   (4),
        .NB_DATA (3)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_data1     (data1),
        .i_data2     (data2),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_sum   (rsp_sum),
        .o_rsp_ovf   (rsp_ovf),
        .o_rsp_id    (rsp_id),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] exp_sum(input int a, input int b);
        int s;
        s = a + b;
`ifdef SUM_RR_SCHED_SAT_EN
        if (s > 7) s = 7;
`endif
        return 3'(s % 8);
    endfunction

    task automatic set_req(input int k, input int a, input int b);
        req_valid[k]       = 1'b1;
        data1[k*3 +: 3]    = 3'(a);
        data2[k*3 +: 3]    = 3'(b);
    endtask

    task automatic next_cycle;
        @(negedge clk);
        #1;
    endtask

    // Single-requester operation with immediate response acceptance.
    task automatic do_op(input string tag, input int k, input int a, input int b);
        set_req(k, a, b);
        #1;
        check({tag, "_ready"}, 32'(req_ready), 32'(4'b1 << k));
        next_cycle();
        req_valid = '0;
        check({tag, "_calc_busy"}, 32'(busy), 32'd1);
        check({tag, "_calc_norsp"}, 32'(rsp_valid), 32'd0);
        next_cycle();
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_sum"}, 32'(rsp_sum), 32'(exp_sum(a, b)));
        check({tag, "_ovf"}, 32'(rsp_ovf), 32'((a + b) > 7));
        check({tag, "_id"}, 32'(rsp_id), 32'(k));
        rsp_ready = 1'b1;
        next_cycle();
        rsp_ready = 1'b0;
        check({tag, "_done"}, 32'(rsp_valid), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        data1     = '0;
        data2     = '0;
        rsp_ready = 1'b0;
        repeat (2) next_cycle();
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_sum", 32'(rsp_sum), 32'd0);
        check("rst_id", 32'(rsp_id), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();

        do_op("t1_r2", 2, 3, 2);
        do_op("t2_r0", 0, 6, 5);
        do_op("t3_max0", 1, 7, 0);
        do_op("t3_max1", 3, 7, 1);

        // All four requesters valid, response always accepted: fair rotation.
        for (int k = 0; k < 4; k++) set_req(k, k, 1);
        rsp_ready = 1'b1;
        #1;
        for (int n = 0; n < 5; n++) begin
            int id;
            id = n % 4;
            check($sformatf("t4_ready_%0d", n), 32'(req_ready), 32'(4'b1 << id));
            next_cycle();
            check($sformatf("t4_calc_%0d", n), 32'(rsp_valid), 32'd0);
            next_cycle();
            check($sformatf("t4_valid_%0d", n), 32'(rsp_valid), 32'd1);
            check($sformatf("t4_id_%0d", n), 32'(rsp_id), 32'(id));
            check($sformatf("t4_sum_%0d", n), 32'(rsp_sum), 32'(id + 1));
            next_cycle();
        end
        req_valid = '0;
        rsp_ready = 1'b0;
        next_cycle();

        // Response stall: ptr is 1, req2 is the only valid, 7+7 overflows.
        set_req(2, 7, 7);
        #1;
        check("t5_ready", 32'(req_ready), 32'b0100);
        next_cycle();
        req_valid = '0;
        set_req(1, 1, 1);
        next_cycle();
        for (int n = 0; n < 5; n++) begin
            check($sformatf("t5_valid_%0d", n), 32'(rsp_valid), 32'd1);
            check($sformatf("t5_sum_%0d", n), 32'(rsp_sum), 32'(exp_sum(7, 7)));
            check($sformatf("t5_ovf_%0d", n), 32'(rsp_ovf), 32'd1);
            check($sformatf("t5_id_%0d", n), 32'(rsp_id), 32'd2);
            check($sformatf("t5_noready_%0d", n), 32'(req_ready), 32'd0);
            next_cycle();
        end
        rsp_ready = 1'b1;
        next_cycle();
        check("t5_released", 32'(rsp_valid), 32'd0);
        check("t5_next_ready", 32'(req_ready), 32'b0010);
        next_cycle();
        req_valid = '0;
        next_cycle();
        check("t5_next_id", 32'(rsp_id), 32'd1);
        check("t5_next_sum", 32'(rsp_sum), 32'd2);
        next_cycle();
        rsp_ready = 1'b0;

        // Reset during CALC: ptr is 2, req3 granted, then discarded.
        set_req(3, 5, 1);
        next_cycle();
        check("t6_calc_busy", 32'(busy), 32'd1);
        req_valid = 4'b1111;
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_valid", 32'(rsp_valid), 32'd0);
        check("t6_rst_ready", 32'(req_ready), 32'd0);
        check("t6_rst_sum", 32'(rsp_sum), 32'd0);
        check("t6_rst_id", 32'(rsp_id), 32'd0);
        req_valid = '0;
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        check("t6_post_valid", 32'(rsp_valid), 32'd0);
        next_cycle();
        check("t6_post_valid2", 32'(rsp_valid), 32'd0);
        check("t6_post_busy", 32'(busy), 32'd0);
        req_valid = 4'b1111;
        #1;
        check("t6_ptr_reset", 32'(req_ready), 32'b0001);
        req_valid = '0;
        next_cycle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
